// File: rtl/req_arbiter8.sv
// req_arbiter8: 8-way request arbiter with fixed-MSB or round-robin priority.
// A grant is held until done, request drop, enable drop or hold timeout.
`default_nettype none

module req_arbiter8 #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            mode_i,
  input  logic [N-1:0]    req_i,
  input  logic            done_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            gnt_valid_o,
  output logic            timeout_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam int HCW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            timeout_q, timeout_d;
  logic [IDXW-1:0] last_idx_q, last_idx_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

  logic [IDXW-1:0] w_win;
  logic [IDXW-1:0] w_cand;
  logic            w_arb;
  logic            w_other;
  logic            w_tmo;

  // Round-robin walks downward from last_idx-1, wrapping, so the last owner is tried last.
  always_comb begin
    w_win  = '0;
    w_cand = '0;
    if (!mode_i) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i]) w_win = IDXW'(i);
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        w_cand = IDXW'((int'(last_idx_q) + N - k) % N);
        if (req_i[w_cand]) w_win = w_cand;
      end
    end
  end

  assign w_arb   = en_i && (|req_i);
  assign w_other = done_i || !req_i[gnt_idx_q] || !en_i;
  assign w_tmo   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    last_idx_d  = last_idx_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      S_IDLE, S_RELEASE: begin
        if (w_arb) begin
          state_d     = S_GRANT;
          gnt_d       = ONE_HOT0 << w_win;
          gnt_idx_d   = w_win;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          state_d     = S_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (w_other || w_tmo) begin
          state_d     = S_RELEASE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = w_tmo && !w_other;
          last_idx_d  = gnt_idx_q;
        end else begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_idx_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      last_idx_q  <= last_idx_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_req_arbiter8.sv
// tb_req_arbiter8: directed scenarios plus randomized traffic against a cycle model of req_arbiter8.
`default_nettype none

module tb_req_arbiter8;

  localparam int N        = 8;
  localparam int IDXW     = 3;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            mode = 1'b0;
  logic [N-1:0]    req = 8'hFF;
  logic            done = 1'b0;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  int n_checks = 0;
  int n_pass   = 0;

  req_arbiter8 #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .mode_i      (mode),
    .req_i       (req),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // Model: who owns the resource, for how many cycles, who owned it last.
  int owner;
  int held;
  int last;
  int m_idx;
  bit m_to;

  function automatic int pick(input logic [N-1:0] r, input logic md, input int lst);
    if (!md) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (r[(lst - k + N) % N]) return (lst - k + N) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = -1; held = 0; last = 0; m_idx = 0; m_to = 0;
    end else if (owner >= 0) begin
      bit other, tmo;
      held  = held + 1;
      tmo   = (MAX_HOLD != 0) && (held == MAX_HOLD);
      other = done || !req[owner] || !en;
      m_to  = 0;
      if (other || tmo) begin
        m_to  = tmo && !other;
        last  = owner;
        owner = -1;
      end
    end else begin
      m_to = 0;
      if (en && req != 0) begin
        owner = pick(req, mode, last);
        held  = 0;
        m_idx = owner;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("gnt",       int'(gnt),       (owner >= 0) ? (1 << owner) : 0);
    check("gnt_valid", int'(gnt_valid), (owner >= 0) ? 1 : 0);
    check("gnt_idx",   int'(gnt_idx),   m_idx);
    check("timeout",   int'(timeout),   int'(m_to));
    check("to_and_valid", int'(timeout && gnt_valid), 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int seq[4] = '{5, 2, 0, 5};

  initial begin
    // Reset holds everything off even with all requests and enable high.
    tick(3);
    check("rst_gnt", int'(gnt), 0);
    check("rst_valid", int'(gnt_valid), 0);
    en = 1'b0; rst = 1'b0;
    tick(3);
    check("en0_gnt", int'(gnt), 0);

    mode = 1'b0; en = 1'b1; req = 8'b1010_0100;
    tick();
    check("fix_gnt", int'(gnt), 8'h80);
    check("fix_idx", int'(gnt_idx), 7);
    done = 1'b1; tick(); done = 1'b0;
    check("fix_dead", int'(gnt), 0);
    tick();
    check("fix_regrant", int'(gnt), 8'h80);
    done = 1'b1; tick(); done = 1'b0;

    // Round-robin from last owner 7: 5,2,0,5 with one dead cycle each.
    mode = 1'b1; req = 8'b0010_0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_idx", int'(gnt_idx), seq[i]);
      check("rr_valid", int'(gnt_valid), 1);
      done = 1'b1; tick(); done = 1'b0;
      check("rr_dead", int'(gnt), 0);
    end
    req = '0; tick();

    mode = 1'b0; req = 8'b0001_0000;
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      check("hold_gnt", int'(gnt), 8'h10);
    end
    tick();
    check("tmo_gnt", int'(gnt), 0);
    check("tmo_pulse", int'(timeout), 1);
    tick();
    check("tmo_regrant", int'(gnt), 8'h10);
    check("tmo_clear", int'(timeout), 0);

    req = 8'h08; tick();
    check("drop_rel", int'(gnt_valid), 0);
    tick();
    check("idx3_gnt", int'(gnt), 8'h08);
    req = 8'h00; tick();
    check("reqdrop_rel", int'(gnt_valid), 0);
    check("reqdrop_to", int'(timeout), 0);
    req = 8'h08; tick(2);
    check("idx3_again", int'(gnt), 8'h08);
    en = 1'b0; tick();
    check("en_abort", int'(gnt_valid), 0);
    tick(3);
    check("en_blocked", int'(gnt_valid), 0);

    en = 1'b1; mode = 1'b1; req = 8'h04; tick();
    check("rr2_idx", int'(gnt_idx), 2);
    #1 rst = 1'b1;
    #1 check("async_gnt", int'(gnt), 0);
    check("async_valid", int'(gnt_valid), 0);
    tick();
    rst = 1'b0; req = 8'b0000_0101; tick();
    check("post_rst_idx", int'(gnt_idx), 2);
    check("post_rst_gnt", int'(gnt), 8'h04);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) < 30) req = (($urandom_range(3) == 0) ? 8'h00 : 8'(($urandom & $urandom)));
      en   = ($urandom_range(99) < 92);
      done = ($urandom_range(99) < 15);
      if ($urandom_range(99) < 10) mode = ~mode;
      rst  = ($urandom_range(999) < 3);
      tick();
    end
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
